// File: rtl/mul_bridge_pkg.sv
// Shared types for the clocked front-end of the self-timed req/fin multiplier.
package mul_bridge_pkg;

    typedef enum logic [2:0] {
        ST_DRAIN,
        ST_IDLE,
        ST_SETUP,
        ST_WAIT_HI,
        ST_CAPTURE,
        ST_WAIT_LO
    } state_t;

    // Reset lands in DRAIN so a multiplier still holding fin high is waited out.
    localparam state_t RESET_STATE = ST_DRAIN;

endpackage

// File: rtl/mul_handshake_bridge_sync2.sv
// Two-flop synchronizer for a single asynchronous level; RST_VAL picks the reset level of both flops.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mul_handshake_bridge.sv
// Valid/ready front-end driving a 4-phase req/fin multiplier; one product in flight at a time.
// Optional per-phase watchdog on err when MUL_BRIDGE_TIMEOUT_EN is defined.
module mul_handshake_bridge
    import mul_bridge_pkg::*;
#(
    parameter int Width   = 32,
    parameter int SETUP   = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [Width-1:0]     in_x,
    input  logic [Width-1:0]     in_y,
    output logic [Width-1:0]     mul_x,
    output logic [Width-1:0]     mul_y,
    output logic                 mul_req,
    input  logic                 mul_fin,
    input  logic [2*Width-1:0]   mul_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*Width-1:0]   out_result,
    output logic                 busy,
    output logic                 err
);

    localparam int CW = (SETUP > 1) ? $clog2(SETUP) : 1;

    state_t        state;
    state_t        next_state;
    logic          fin_s;
    logic [CW-1:0] cnt;
    logic          slot_free;
    logic          accept;
    logic          req_set;
    logic          load_res;

    sync2 #(.RST_VAL(1'b1)) u_fin_sync (
        .clk (clk),
        .rst (rst),
        .d   (mul_fin),
        .q   (fin_s)
    );

    // A held product leaving this cycle frees the slot for a same-cycle reload.
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_DRAIN:   if (!fin_s)       next_state = ST_IDLE;
            ST_IDLE:    if (in_valid)     next_state = ST_SETUP;
            ST_SETUP:   if (cnt == '0)    next_state = ST_WAIT_HI;
            ST_WAIT_HI: if (fin_s)        next_state = ST_CAPTURE;
            ST_CAPTURE: if (slot_free)    next_state = ST_WAIT_LO;
            ST_WAIT_LO: if (!fin_s)       next_state = ST_IDLE;
            default:                      next_state = ST_DRAIN;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        accept   = (state == ST_IDLE) && in_valid;
        req_set  = (state == ST_SETUP) && (cnt == '0);
        load_res = (state == ST_CAPTURE) && slot_free;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_x      <= '0;
            mul_y      <= '0;
            mul_req    <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            if (accept) begin
                mul_x <= in_x;
                mul_y <= in_y;
                cnt   <= CW'(SETUP - 1);
            end else if ((state == ST_SETUP) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end

            if (req_set) begin
                mul_req <= 1'b1;
            end else if (load_res) begin
                mul_req <= 1'b0;
            end

            if (load_res) begin
                out_result <= mul_result;
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUL_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt;
    logic          waiting;

    assign waiting = (state == ST_WAIT_HI) || (state == ST_WAIT_LO);

    // Counter restarts on every state change; err only flags, the FSM keeps waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (next_state != state) begin
                wd_cnt <= '0;
            end else if (waiting && (wd_cnt != TW'(TIMEOUT))) begin
                wd_cnt <= wd_cnt + TW'(1);
            end
            if (waiting && (wd_cnt == TW'(TIMEOUT - 1))) begin
                err <= 1'b1;
            end
        end
    end
`else
    // No watchdog: TIMEOUT only appears here so the expression folds to 0.
    assign err = (TIMEOUT < 0);
`endif

endmodule
